// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU sequencer: state encoding, opcode bit
// positions and default parameter values.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int OP_FUNC_LO = 0;
    localparam int OP_FUNC_HI = 1;
    localparam int OP_LOAD    = 2;
    localparam int OP_JUMP    = 3;

    localparam int DEF_MEM_TIMEOUT = 15;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/cpu_sequencer_op_decode.sv
// Opcode decoder: turns the 4-bit instruction register into the control
// qualifiers used by EXEC, MEM and WB.
module op_decode
    import cpu_seq_pkg::*;
(
    input  logic [3:0] ir,
    output logic [1:0] func,
    output logic       load,
    output logic       store,
    output logic       jump,
    output logic       wr,
    output logic       inc
);

    assign func  = ir[OP_FUNC_HI:OP_FUNC_LO];
    assign load  = ir[OP_LOAD];
    assign store = ir[OP_FUNC_HI] & ~ir[OP_FUNC_LO];
    assign jump  = ir[OP_JUMP];
    assign wr    = ir[OP_JUMP] | ~ir[OP_FUNC_HI];
    assign inc   = ~ir[OP_JUMP];

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// timeout into a sticky error state. All strobes are Moore outputs.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic [3:0]       instr_data,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             alu_en,
    output logic [1:0]       alu_func,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             reg_write,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [3:0]        ir;
    logic [WT_W-1:0]   wait_cnt;
    logic [1:0]        func;
    logic              load, store, jump, wr, inc;
    logic              timeout;

    op_decode u_dec (
        .ir    (ir),
        .func  (func),
        .load  (load),
        .store (store),
        .jump  (jump),
        .wr    (wr),
        .inc   (inc)
    );

    // Last stalled cycle of a request: ack still wins if it arrives now.
    assign timeout = (wait_cnt == WT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ir       <= 4'd0;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && mem_ack)
                ir <= instr_data;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (mem_req && !mem_ack)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == S_WB)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        alu_en    = 1'b0;
        alu_func  = 2'b00;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        reg_write = 1'b0;
        busy      = 1'b1;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack)      state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_ERR;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                alu_en    = 1'b1;
                alu_func  = func;
                pc_load   = jump;
                state_nxt = ((load | store) & ~jump) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = store;
                if (mem_ack)      state_nxt = S_WB;
                else if (timeout) state_nxt = S_ERR;
            end
            S_WB: begin
                reg_write = wr;
                pc_inc    = inc;
                state_nxt = halt_req ? S_IDLE : S_FETCH;
            end
            S_ERR: begin
                busy = 1'b0;
                err  = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: table-driven opcode vectors, randomized
// instruction streams against a transaction-level model, and corner cases.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, halt_req, mem_ack;
    logic [3:0] instr_data;
    logic       mem_req, mem_we, alu_en, pc_inc, pc_load, reg_write, busy, err;
    logic [1:0] alu_func;
    logic [3:0] retired;

    cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .instr_data(instr_data), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_we(mem_we), .alu_en(alu_en), .alu_func(alu_func),
        .pc_inc(pc_inc), .pc_load(pc_load), .reg_write(reg_write),
        .busy(busy), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, alu_en;
        logic [1:0] alu_func;
        logic       pc_inc, pc_load, reg_write, busy, err;
    } outs_t;

    typedef struct {
        logic [3:0] op;
        logic [1:0] func;
        logic       jmp, has_mem, we, wr, inc;
        int         fd, md;
    } vec_t;

    outs_t      act;
    int         tests = 0, fails = 0;
    logic [3:0] mret;

    assign act = {mem_req, mem_we, alu_en, alu_func, pc_inc, pc_load, reg_write, busy, err};

    localparam outs_t O_IDLE  = 10'b0;
    localparam outs_t O_BUSY  = 10'b0000000010;
    localparam outs_t O_ERR   = 10'b0000000001;

    function automatic outs_t o_mem(input logic we);
        outs_t o = O_BUSY;
        o.mem_req = 1'b1;
        o.mem_we  = we;
        return o;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input outs_t e, input logic [3:0] er);
        tests++;
        if (act !== e || retired !== er) begin
            fails++;
            $display("FAIL %s: got outs=%b retired=%0d, expected outs=%b retired=%0d",
                     nm, act, retired, e, er);
        end
    endtask

    // Spec decode rules written as opcode arithmetic.
    task automatic model(input logic [3:0] op, output vec_t v);
        int o = int'(op);
        v.op      = op;
        v.func    = 2'(o % 4);
        v.jmp     = (o >= 8);
        v.we      = ((o % 4) == 2);
        v.has_mem = ((((o / 4) % 2) == 1) || v.we) && !v.jmp;
        v.wr      = v.jmp || (((o / 2) % 2) == 0);
        v.inc     = !v.jmp;
        v.fd      = 0;
        v.md      = 0;
    endtask

    // One full instruction; caller is in IDLE (from_idle) or already in FETCH.
    task automatic do_instr(input vec_t v, input logic halt, input logic from_idle);
        outs_t e;
        if (from_idle) begin
            chk("idle", O_IDLE, mret);
            start = 1'b1;
            cyc();
            start = 1'b0;
        end
        for (int i = 0; i <= v.fd; i++) begin
            instr_data = (i == v.fd) ? v.op : 4'($urandom);
            mem_ack    = (i == v.fd);
            chk("fetch", o_mem(1'b0), mret);
            cyc();
        end
        mem_ack = 1'($urandom);
        chk("decode", O_BUSY, mret);
        cyc();
        e = O_BUSY; e.alu_en = 1'b1; e.alu_func = v.func; e.pc_load = v.jmp;
        halt_req = 1'($urandom); start = 1'($urandom); mem_ack = 1'b0;
        chk("exec", e, mret);
        cyc();
        halt_req = 1'b0; start = 1'b0;
        if (v.has_mem) begin
            for (int i = 0; i <= v.md; i++) begin
                mem_ack = (i == v.md);
                chk("mem", o_mem(v.we), mret);
                cyc();
            end
            mem_ack = 1'b0;
        end
        e = O_BUSY; e.reg_write = v.wr; e.pc_inc = v.inc;
        halt_req = halt;
        chk("wb", e, mret);
        cyc();
        halt_req = 1'b0;
        mret = mret + 4'd1;
        if (halt) chk("halt_idle", O_IDLE, mret);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        chk("reset", O_IDLE, 4'd0);
        rst_n = 1'b1;
        mret  = 4'd0;
    endtask

    vec_t tbl[9];
    vec_t v;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ack = 1'b0; instr_data = 4'd0;
        mret = 4'd0;
        cyc(); cyc();
        chk("reset_init", O_IDLE, 4'd0);
        rst_n = 1'b1;
        cyc();
        chk("idle_after_reset", O_IDLE, 4'd0);

        //          op      func  jmp  mem  we   wr   inc  fd  md
        tbl[0] = '{4'b0001, 2'b01, 0,  0,   0,   1,   1,   1,  1};
        tbl[1] = '{4'b0110, 2'b10, 0,  1,   1,   0,   1,   1,  1};
        tbl[2] = '{4'b1000, 2'b00, 1,  0,   0,   1,   0,   1,  1};
        tbl[3] = '{4'b0100, 2'b00, 0,  1,   0,   1,   1,   0,  0};
        tbl[4] = '{4'b0111, 2'b11, 0,  1,   0,   0,   1,  14, 14};
        tbl[5] = '{4'b1110, 2'b10, 1,  0,   0,   1,   0,   3,  0};
        tbl[6] = '{4'b0010, 2'b10, 0,  1,   1,   0,   1,   2, 14};
        tbl[7] = '{4'b0011, 2'b11, 0,  0,   0,   0,   1,   0,  0};
        tbl[8] = '{4'b0000, 2'b00, 0,  0,   0,   1,   1,   5,  0};
        foreach (tbl[i]) do_instr(tbl[i], 1'b1, 1'b1);

        // Randomized back-to-back stream with random ack latency and halts.
        begin
            logic idle = 1'b1;
            for (int n = 0; n < 40; n++) begin
                logic h;
                model(4'($urandom), v);
                v.fd = $urandom_range(0, 14);
                v.md = $urandom_range(0, 14);
                h = ($urandom_range(0, 5) == 0) || (n == 39);
                do_instr(v, h, idle);
                idle = h;
            end
        end

        // Fetch timeout: 15 stalled cycles, then sticky ERR until reset.
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("fetch_stall", o_mem(1'b0), mret);
            cyc();
        end
        chk("err_fetch", O_ERR, mret);
        start = 1'b1; mem_ack = 1'b1; halt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("err_hold", O_ERR, mret);
        end
        start = 1'b0; mem_ack = 1'b0; halt_req = 1'b0;
        do_reset();
        cyc();
        chk("idle_after_err", O_IDLE, 4'd0);

        // Memory-phase timeout.
        start = 1'b1; cyc(); start = 1'b0;
        instr_data = 4'b0100; mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 15; i++) begin
            chk("mem_stall", o_mem(1'b0), mret);
            cyc();
        end
        chk("err_mem", O_ERR, mret);
        do_reset();

        // Retire one instruction, then reset in the middle of a store.
        model(4'b0001, v);
        do_instr(v, 1'b1, 1'b1);
        start = 1'b1; cyc(); start = 1'b0;
        instr_data = 4'b0110; mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
        cyc(); cyc();
        chk("mem_before_reset", o_mem(1'b1), 4'd1);
        rst_n = 1'b0; mem_ack = 1'b1;
        cyc();
        chk("reset_mid_mem", O_IDLE, 4'd0);
        rst_n = 1'b1; mem_ack = 1'b0; mret = 4'd0;
        cyc();
        chk("idle_after_mid_reset", O_IDLE, 4'd0);

        // Counter wrap: 15 retirements, then the 16th wraps to 0 with halt.
        for (int n = 0; n < 16; n++) begin
            model(4'($urandom), v);
            do_instr(v, (n == 15), (n == 0));
        end
        chk("wrap_zero", O_IDLE, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
